// File: rtl/clk_glitch_monitor_pkg.sv
// Shared constants and level-state type for the clk_glitch_monitor slice.
package clk_mon_pkg;

  localparam int unsigned MIN_PULSE_DEF = 3;
  localparam int unsigned TIMEOUT_DEF   = 200;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

endpackage

// File: rtl/clk_glitch_monitor_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/clk_glitch_monitor.sv
// Oversampling phase-width monitor for a switched clock; flags phases shorter
// than MIN_PULSE. Optional stuck detector built when STUCK_DET_EN is defined.
module clk_glitch_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned MIN_PULSE = MIN_PULSE_DEF,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             clear,
  output logic [W-1:0]     high_w,
  output logic [W-1:0]     low_w,
  output logic             meas_valid,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             stuck
);

  localparam logic [W-1:0]     WIDTH_MAX = '1;
  localparam logic [W-1:0]     MIN_W     = W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             w_s2;
  phase_t           r_prev;
  logic             w_edge;
  logic             w_fall;
  logic             w_short;
  logic [W-1:0]     r_cnt;
  logic             r_armed;
  logic [W-1:0]     r_high_w;
  logic [W-1:0]     r_low_w;
  logic             r_meas_valid;
  logic             r_glitch;
  logic [CNT_W-1:0] r_gcnt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (clk_in),
    .o_q   (w_s2)
  );

  assign w_edge  = (phase_t'(w_s2) != r_prev);
  assign w_fall  = !w_s2 && (r_prev == PH_HIGH);
  // A saturated width means the level held too long to measure, never a runt.
  assign w_short = (r_cnt < MIN_W) && (r_cnt != WIDTH_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev       <= PH_LOW;
      r_cnt        <= '0;
      r_armed      <= 1'b0;
      r_high_w     <= '0;
      r_low_w      <= '0;
      r_meas_valid <= 1'b0;
      r_glitch     <= 1'b0;
      r_gcnt       <= '0;
    end else begin
      r_prev       <= phase_t'(w_s2);
      r_meas_valid <= 1'b0;
      if (w_edge) begin
        r_cnt <= W'(1);
      end else if (r_cnt != WIDTH_MAX) begin
        r_cnt <= r_cnt + W'(1);
      end
      // Clear takes priority over a coincident edge: nothing reported, stays unarmed.
      if (clear) begin
        r_armed  <= 1'b0;
        r_glitch <= 1'b0;
        r_gcnt   <= '0;
      end else if (w_edge) begin
        r_armed <= 1'b1;
        if (r_armed) begin
          r_meas_valid <= 1'b1;
          if (w_fall) begin
            r_high_w <= r_cnt;
          end else begin
            r_low_w <= r_cnt;
          end
          if (w_short) begin
            r_glitch <= 1'b1;
            if (r_gcnt != CNT_MAX) begin
              r_gcnt <= r_gcnt + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  assign high_w     = r_high_w;
  assign low_w      = r_low_w;
  assign meas_valid = r_meas_valid;
  assign glitch     = r_glitch;
  assign glitch_cnt = r_gcnt;

`ifdef STUCK_DET_EN
  localparam int unsigned TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT);

  logic [TW-1:0] r_idle;
  logic          r_stuck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle  <= '0;
      r_stuck <= 1'b0;
    end else if (w_edge || clear) begin
      r_idle  <= '0;
      r_stuck <= 1'b0;
    end else begin
      if (r_idle != T_LIM) begin
        r_idle <= r_idle + TW'(1);
      end
      if (r_idle == T_LIM - TW'(1)) begin
        r_stuck <= 1'b1;
      end
    end
  end

  assign stuck = r_stuck;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign stuck            = 1'b0;
`endif

endmodule

// File: tb/tb_clk_glitch_monitor.sv
// Scoreboard bench for clk_glitch_monitor: phases of known cycle length are
// driven synchronously; a phase-level model predicts every report.
`timescale 1ns/100ps
module tb_clk_glitch_monitor;

  localparam int unsigned W         = 8;
  localparam int unsigned MIN_PULSE = 3;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned TIMEOUT   = 200;
  localparam int unsigned WMAX      = (1 << W) - 1;
  localparam int unsigned CMAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clk_in;
  logic             clear;
  logic [W-1:0]     high_w;
  logic [W-1:0]     low_w;
  logic             meas_valid;
  logic             glitch;
  logic [CNT_W-1:0] glitch_cnt;
  logic             stuck;

  clk_glitch_monitor #(
    .W         (W),
    .MIN_PULSE (MIN_PULSE),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_in     (clk_in),
    .clear      (clear),
    .high_w     (high_w),
    .low_w      (low_w),
    .meas_valid (meas_valid),
    .glitch     (glitch),
    .glitch_cnt (glitch_cnt),
    .stuck      (stuck)
  );

  always #1 clk = ~clk;

  typedef struct {
    int unsigned hw;
    int unsigned lw;
    bit          g;
    int unsigned gc;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          m_armed;
  int unsigned m_prev_len;
  int unsigned m_gcnt;
  int unsigned m_high;
  int unsigned m_low;

  function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // A level boundary completes the previous phase; the first boundary after
  // reset or clear only arms the monitor.
  task automatic model_boundary(input bit ending_high);
    exp_t e;
    int unsigned w;
    if (m_armed) begin
      w = sat(m_prev_len, WMAX);
      if (ending_high) m_high = w;
      else             m_low  = w;
      if (w < MIN_PULSE) m_gcnt = sat(m_gcnt + 1, CMAX);
      e.hw = m_high;
      e.lw = m_low;
      e.g  = (m_gcnt != 0);
      e.gc = m_gcnt;
      q.push_back(e);
    end
    m_armed = 1'b1;
  endtask

  task automatic drive_phase(input int unsigned len, input bit do_clear);
    @(negedge clk);
    model_boundary(clk_in);
    clk_in     = ~clk_in;
    m_prev_len = len;
    for (int unsigned i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      if (do_clear) begin
        clear = (i == 4);
        if (i == 4) begin
          m_armed = 1'b0;
          m_gcnt  = 0;
        end
        if (i == 6) begin
          chk("clear_glitch", glitch, 0);
          chk("clear_cnt", glitch_cnt, 0);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #0.5 rst_n = 1'b0;
    #0.2;
    chk("rst_high_w", high_w, 0);
    chk("rst_low_w", low_w, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_glitch", glitch, 0);
    chk("rst_glitch_cnt", glitch_cnt, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_queue_drained", q.size(), 0);
    q.delete();
    clk_in  = 1'b0;
    clear   = 1'b0;
    m_armed = 1'b0;
    m_gcnt  = 0;
    m_high  = 0;
    m_low   = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_meas_valid actual=1 expected=0 at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("high_w", high_w, e.hw);
        chk("low_w", low_w, e.lw);
        chk("glitch", glitch, e.g);
        chk("glitch_cnt", glitch_cnt, e.gc);
        chk("stuck_at_meas", stuck, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b1;
    clk_in = 1'b0;
    clear  = 1'b0;
    do_reset();

    // 20ns clk_in period: 5-cycle phases
    for (int i = 0; i < 8; i++) drive_phase(5, 1'b0);
    // 30ns clk_in period: alternating 7/8-cycle phases
    for (int i = 0; i < 8; i++) drive_phase((i % 2 == 0) ? 7 : 8, 1'b0);

    // Long high hold: width saturates, no glitch, stuck only with the detector
    if (clk_in) drive_phase(5, 1'b0);
    fork
      begin
        repeat (260) @(negedge clk);
`ifdef STUCK_DET_EN
        chk("stuck_hold", stuck, 1);
`else
        chk("stuck_hold", stuck, 0);
`endif
      end
    join_none
    drive_phase(300, 1'b0);
    drive_phase(5, 1'b0);
    chk("stuck_after_edge", stuck, 0);
    for (int i = 0; i < 3; i++) drive_phase(5, 1'b0);

    // High runt of 2 cycles while switching period
    if (clk_in) drive_phase(7, 1'b0);
    drive_phase(2, 1'b0);
    drive_phase(5, 1'b0);
    chk("runt_high_w", high_w, 2);
    chk("runt_glitch", glitch, 1);
    chk("runt_cnt", glitch_cnt, 1);
    for (int i = 0; i < 6; i++) drive_phase(5, 1'b0);
    chk("runt_sticky", glitch, 1);

    // Randomised phase lengths with occasional clears
    for (int i = 0; i < 40; i++) begin
      int unsigned len;
      len = $urandom_range(12, 1);
      drive_phase(len, (len >= 8) && ($urandom_range(3, 0) == 0));
    end

    // Three one-cycle runts after a clear, then clear again
    drive_phase(10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_phase(5, 1'b0);
      drive_phase(1, 1'b0);
    end
    drive_phase(5, 1'b0);
    chk("three_runts_cnt", glitch_cnt, 3);
    chk("three_runts_glitch", glitch, 1);
    drive_phase(10, 1'b1);
    for (int i = 0; i < 4; i++) drive_phase(5, 1'b0);

    // Asynchronous reset in the middle of a phase, then resume
    drive_phase(10, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) drive_phase($urandom_range(9, 1), 1'b0);

    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
